// File: rtl/decipher_if.sv
// decipher_if -- bundles the decipher start/data, S-table read port and result
// signals into one interface.
//   slave  : the decipher engine (takes start/ciphertext/S data, drives
//            S addresses and plaintext/done)
//   master : whoever drives the engine and serves the S-table reads
// Signals:
//   iStart               start request (sampled only while the engine is idle)
//   iA, iB               ciphertext word pair, captured with iStart
//   oS_address1/2        registered S-table addresses (even / odd entry)
//   iS_sub_i1/2          S-table read data for oS_address1/2
//   oA_plain, oB_plain   registered plaintext result
//   oDone                result valid level
interface decipher_if #(
  parameter int W        = 32,
  parameter int T_LENGTH = 5
);
  logic                iStart;
  logic [W-1:0]        iA;
  logic [W-1:0]        iB;
  logic [T_LENGTH-1:0] oS_address1;
  logic [T_LENGTH-1:0] oS_address2;
  logic [W-1:0]        iS_sub_i1;
  logic [W-1:0]        iS_sub_i2;
  logic [W-1:0]        oA_plain;
  logic [W-1:0]        oB_plain;
  logic                oDone;

  modport slave (
    input  iStart, iA, iB, iS_sub_i1, iS_sub_i2,
    output oS_address1, oS_address2, oA_plain, oB_plain, oDone
  );

  modport master (
    output iStart, iA, iB, iS_sub_i1, iS_sub_i2,
    input  oS_address1, oS_address2, oA_plain, oB_plain, oDone
  );
endinterface

// File: rtl/decipher.sv
// decipher -- RC5 block decryption engine (inverse of cipher).
// Runs R rounds over the expanded key table S, read through a registered
// dual-address port so it can share one S RAM with the encryption engine.
// Ports:
//   clk   clock, all state on the rising edge
//   rst   synchronous active-high reset
//   bus   decipher_if.slave: iStart/iA/iB in, oS_address1/2 out,
//         iS_sub_i1/2 in, oA_plain/oB_plain/oDone out
// Each round takes 5 cycles: one RAM latency cycle after the address change,
// then subtract/rotate-xor for B followed by the same for A. A final pair of
// cycles removes S[0]/S[1]; oDone rises 5R+2 cycles after the start.
module decipher #(
  parameter int W = 32,
  parameter int R = 12
) (
  input  logic     clk,
  input  logic     rst,
  decipher_if.slave bus
);

  localparam int T         = 2 * (R + 1);
  localparam int T_LENGTH  = $clog2(T);
  localparam int ROT_VALUE = $clog2(W);
  localparam int CNT_BITS  = $clog2(R + 1);

  localparam logic [T_LENGTH-1:0] ADDR_TOP_EVEN = T_LENGTH'(2 * R);
  localparam logic [T_LENGTH-1:0] ADDR_TOP_ODD  = T_LENGTH'(2 * R + 1);
  localparam logic [CNT_BITS-1:0] CNT_START     = CNT_BITS'(R);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SUB_B,
    S_ROTX_B,
    S_SUB_A,
    S_ROTX_A,
    S_FINAL_WAIT,
    S_FINAL
  } state_t;

  state_t              r_state, w_state_next;
  logic [W-1:0]        r_a, w_a_next;
  logic [W-1:0]        r_b, w_b_next;
  logic [CNT_BITS-1:0] r_count, w_count_next;
  logic [T_LENGTH-1:0] r_addr1, w_addr1_next;
  logic [T_LENGTH-1:0] r_addr2, w_addr2_next;
  logic [W-1:0]        r_a_plain, w_a_plain_next;
  logic [W-1:0]        r_b_plain, w_b_plain_next;
  logic                r_done, w_done_next;
  logic [CNT_BITS-1:0] w_cnt_dec;

  // Rotate right by the low ROT_VALUE bits only; doubling the word keeps the
  // rotate-by-zero case free of an out-of-range shift.
  function automatic logic [W-1:0] rotr(input logic [W-1:0] x,
                                        input logic [ROT_VALUE-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} >> n;
    return t[W-1:0];
  endfunction

  assign w_cnt_dec = r_count - CNT_BITS'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_count   <= '0;
      r_addr1   <= '0;
      r_addr2   <= T_LENGTH'(1);
      r_a_plain <= '0;
      r_b_plain <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_a       <= w_a_next;
      r_b       <= w_b_next;
      r_count   <= w_count_next;
      r_addr1   <= w_addr1_next;
      r_addr2   <= w_addr2_next;
      r_a_plain <= w_a_plain_next;
      r_b_plain <= w_b_plain_next;
      r_done    <= w_done_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_a_next       = r_a;
    w_b_next       = r_b;
    w_count_next   = r_count;
    w_addr1_next   = r_addr1;
    w_addr2_next   = r_addr2;
    w_a_plain_next = r_a_plain;
    w_b_plain_next = r_b_plain;
    w_done_next    = r_done;

    case (r_state)
      S_IDLE: begin
        if (bus.iStart) begin
          w_a_next     = bus.iA;
          w_b_next     = bus.iB;
          w_count_next = CNT_START;
          w_addr1_next = ADDR_TOP_EVEN;
          w_addr2_next = ADDR_TOP_ODD;
          w_done_next  = 1'b0;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: w_state_next = S_SUB_B;
      S_SUB_B: begin
        w_b_next     = r_b - bus.iS_sub_i2;
        w_state_next = S_ROTX_B;
      end
      S_ROTX_B: begin
        w_b_next     = rotr(r_b, r_a[ROT_VALUE-1:0]) ^ r_a;
        w_state_next = S_SUB_A;
      end
      S_SUB_A: begin
        w_a_next     = r_a - bus.iS_sub_i1;
        w_state_next = S_ROTX_A;
      end
      S_ROTX_A: begin
        w_a_next = rotr(r_a, r_b[ROT_VALUE-1:0]) ^ r_b;
        if (r_count == CNT_BITS'(1)) begin
          // Last round done: point at S[0]/S[1] for the final whitening.
          w_addr1_next = '0;
          w_addr2_next = T_LENGTH'(1);
          w_state_next = S_FINAL_WAIT;
        end else begin
          w_count_next = w_cnt_dec;
          w_addr1_next = {w_cnt_dec, 1'b0};
          w_addr2_next = {w_cnt_dec, 1'b1};
          w_state_next = S_WAIT;
        end
      end
      S_FINAL_WAIT: w_state_next = S_FINAL;
      S_FINAL: begin
        w_a_plain_next = r_a - bus.iS_sub_i1;
        w_b_plain_next = r_b - bus.iS_sub_i2;
        w_done_next    = 1'b1;
        w_state_next   = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bus.oS_address1 = r_addr1;
  assign bus.oS_address2 = r_addr2;
  assign bus.oA_plain    = r_a_plain;
  assign bus.oB_plain    = r_b_plain;
  assign bus.oDone       = r_done;

endmodule

// File: tb/tb_decipher.sv
// tb_decipher -- self-checking bench for decipher (RC5-32/12 decryption).
// A behavioural RC5 model (key expansion, encrypt, decrypt) plus a
// cycle-level expectation of addresses, oDone and result registers is checked
// against the DUT on every cycle; directed runs add literal expectations.
module tb_decipher;
  localparam int W    = 32;
  localparam int R    = 12;
  localparam int T    = 2 * (R + 1);
  localparam int TLEN = 5;
  localparam int LAT  = 5 * R + 2;

  logic clk;
  logic rst;

  decipher_if #(.W(W), .T_LENGTH(TLEN)) bus ();

  decipher #(.W(W), .R(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RC5 reference model ----------------
  logic [31:0] s_tab [0:31];

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [31:0] n);
    logic [63:0] t;
    t = {x, x} << n[4:0];
    return t[63:32];
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [31:0] n);
    logic [63:0] t;
    t = {x, x} >> n[4:0];
    return t[31:0];
  endfunction

  task automatic expand_zero_key();
    logic [31:0] l [0:3];
    logic [31:0] a, b;
    int i, j;
    for (int k = 0; k < 4; k++) l[k] = 32'h0;
    s_tab[0] = 32'hB7E15163;
    for (int k = 1; k < T; k++) s_tab[k] = s_tab[k-1] + 32'h9E3779B9;
    a = 0; b = 0; i = 0; j = 0;
    for (int k = 0; k < 3 * T; k++) begin
      a = rotl32(s_tab[i] + a + b, 3);
      s_tab[i] = a;
      b = rotl32(l[j] + a + b, a + b);
      l[j] = b;
      i = (i + 1) % T;
      j = (j + 1) % 4;
    end
  endtask

  function automatic logic [63:0] rc5_enc(input logic [31:0] pa, input logic [31:0] pb);
    logic [31:0] a, b;
    a = pa + s_tab[0];
    b = pb + s_tab[1];
    for (int i = 1; i <= R; i++) begin
      a = rotl32(a ^ b, b) + s_tab[2*i];
      b = rotl32(b ^ a, a) + s_tab[2*i+1];
    end
    return {a, b};
  endfunction

  function automatic logic [63:0] rc5_dec(input logic [31:0] ca, input logic [31:0] cb);
    logic [31:0] a, b;
    a = ca; b = cb;
    for (int i = R; i >= 1; i--) begin
      b = rotr32(b - s_tab[2*i+1], a) ^ a;
      a = rotr32(a - s_tab[2*i], b) ^ b;
    end
    return {a - s_tab[0], b - s_tab[1]};
  endfunction

  // ---------------- S-table RAM model ----------------
  // Data is only valid from the second cycle an address is held; in the
  // first cycle after a change the port returns random junk.
  logic [4:0]  a1_prev, a2_prev;
  logic [31:0] junk1, junk2;
  always @(posedge clk) begin
    a1_prev <= bus.oS_address1;
    a2_prev <= bus.oS_address2;
    junk1   <= $urandom;
    junk2   <= $urandom;
  end
  assign bus.iS_sub_i1 = (bus.oS_address1 == a1_prev) ? s_tab[bus.oS_address1] : junk1;
  assign bus.iS_sub_i2 = (bus.oS_address2 == a2_prev) ? s_tab[bus.oS_address2] : junk2;

  // ---------------- cycle-level expectation ----------------
  bit          model_valid = 1'b0;
  bit          m_busy;
  int          m_k;
  bit          m_done;
  logic [31:0] m_pa, m_pb, m_ra, m_rb;

  always @(posedge clk) begin
    if (rst) begin
      model_valid <= 1'b1;
      m_busy <= 1'b0; m_k <= 0; m_done <= 1'b0;
      m_pa <= 32'h0; m_pb <= 32'h0;
    end else if (!m_busy) begin
      if (bus.iStart) begin
        logic [63:0] r;
        r = rc5_dec(bus.iA, bus.iB);
        m_busy <= 1'b1; m_k <= 0; m_done <= 1'b0;
        m_ra <= r[63:32]; m_rb <= r[31:0];
      end
    end else if (m_k == LAT - 1) begin
      m_busy <= 1'b0; m_done <= 1'b1;
      m_pa <= m_ra; m_pb <= m_rb;
    end else begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      logic [31:0] ea;
      ea = (m_busy && m_k < 5 * R) ? 32'(2 * (R - m_k / 5)) : 32'h0;
      check("addr1", 32'(bus.oS_address1), ea);
      check("addr2", 32'(bus.oS_address2), ea + 1);
      check("done", 32'(bus.oDone), 32'(m_done));
      check("a_plain", bus.oA_plain, m_pa);
      check("b_plain", bus.oB_plain, m_pb);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.oDone && n < 100);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ea, input logic [31:0] eb, input string tag);
    int n;
    bus.iA = a; bus.iB = b; bus.iStart = 1'b1;
    @(posedge clk); #2;
    bus.iStart = 1'b0;
    wait_done(n);
    check({tag, "_latency"}, 32'(n), 32'(LAT));
    check({tag, "_a"}, bus.oA_plain, ea);
    check({tag, "_b"}, bus.oB_plain, eb);
    $display("run %s: c=%08h_%08h p=%08h_%08h cycles=%0d", tag, a, b, bus.oA_plain, bus.oB_plain, n);
  endtask

  initial begin
    logic [63:0] v;
    logic [31:0] pa, pb, p2a, p2b;
    int n;
    rst = 1'b1; bus.iStart = 1'b0; bus.iA = 0; bus.iB = 0;
    for (int k = 0; k < 32; k++) s_tab[k] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(bus.oDone), 32'h0);
    check("rst_addr2", 32'(bus.oS_address2), 32'h1);
    #1 rst = 1'b0;

    // Known answer: all-zero key, zero plaintext.
    expand_zero_key();
    v = rc5_enc(32'h0, 32'h0);
    check("model_enc_a", v[63:32], 32'hEEDBA521);
    check("model_enc_b", v[31:0], 32'h6D8F4B15);
    v = rc5_dec(32'hEEDBA521, 32'h6D8F4B15);
    check("model_dec", v[63:32] | v[31:0], 32'h0);
    run(32'hEEDBA521, 32'h6D8F4B15, 32'h0, 32'h0, "kat");

    // Round trip with a random key table.
    for (int k = 0; k < T; k++) s_tab[k] = $urandom;
    for (int t = 0; t < 100; t++) begin
      pa = $urandom; pb = $urandom;
      v = rc5_enc(pa, pb);
      run(v[63:32], v[31:0], pa, pb, "rt");
    end

    // Start held high while busy, inputs changing every cycle.
    pa = $urandom; pb = $urandom;
    v = rc5_enc(pa, pb);
    bus.iA = v[63:32]; bus.iB = v[31:0]; bus.iStart = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      #2 bus.iA = $urandom; bus.iB = $urandom;
      @(posedge clk); #1;
      n++;
    end while (!bus.oDone && n < 100);
    check("busy_latency", 32'(n), 32'(LAT));
    check("busy_a", bus.oA_plain, pa);
    check("busy_b", bus.oB_plain, pb);
    $display("busy run: p=%08h_%08h cycles=%0d", bus.oA_plain, bus.oB_plain, n);
    p2a = $urandom; p2b = $urandom;
    v = rc5_enc(p2a, p2b);
    #1 bus.iA = v[63:32]; bus.iB = v[31:0];
    @(posedge clk); #1;
    check("b2b_done_drop", 32'(bus.oDone), 32'h0);
    check("b2b_a_hold", bus.oA_plain, pa);
    #1 bus.iStart = 1'b0;
    wait_done(n);
    check("b2b_latency", 32'(n), 32'(LAT));
    check("b2b_a", bus.oA_plain, p2a);
    check("b2b_b", bus.oB_plain, p2b);
    $display("back-to-back run: p=%08h_%08h cycles=%0d", bus.oA_plain, bus.oB_plain, n);

    // Reset in the middle of a run.
    v = rc5_enc(32'h12345678, 32'h9ABCDEF0);
    bus.iA = v[63:32]; bus.iB = v[31:0]; bus.iStart = 1'b1;
    @(posedge clk); #2 bus.iStart = 1'b0;
    repeat (30) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_done", 32'(bus.oDone), 32'h0);
    check("mid_rst_a", bus.oA_plain, 32'h0);
    check("mid_rst_b", bus.oB_plain, 32'h0);
    check("mid_rst_addr1", 32'(bus.oS_address1), 32'h0);
    check("mid_rst_addr2", 32'(bus.oS_address2), 32'h1);
    $display("reset mid-run: done=%0d a=%08h addr=%0d/%0d", bus.oDone, bus.oA_plain, bus.oS_address1, bus.oS_address2);
    #1 rst = 1'b0;
    run(v[63:32], v[31:0], 32'h12345678, 32'h9ABCDEF0, "post_rst");

    // Zero corner.
    for (int k = 0; k < 32; k++) s_tab[k] = 32'h0;
    run(32'h0, 32'h0, 32'h0, 32'h0, "zero");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
